// File: rtl/sound_glu_rw_if.sv
// Bus, sound-RAM and DOC signals of the sound GLU grouped as one port bundle.
interface sound_glu_rw_if #(
    parameter int MEM_ADDR_W = 21,
    parameter int LANES      = 4
);
    logic [15:0]           addr_i;
    logic                  sel_i;
    logic                  rw_n_i;
    logic                  wr_strobe_i;
    logic                  rd_strobe_i;
    logic [7:0]            data_i;
    logic [7:0]            data_o;
    logic                  rd_en_o;
    logic [MEM_ADDR_W-1:0] mem_addr_o;
    logic                  mem_wr_o;
    logic                  mem_rd_o;
    logic [LANES-1:0]      mem_byte_en_o;
    logic [8*LANES-1:0]    mem_data_o;
    logic [8*LANES-1:0]    mem_q_i;
    logic                  mem_ready_i;
    logic                  doc_cs_o;
    logic                  doc_we_o;
    logic [7:0]            doc_addr_o;
    logic [7:0]            doc_data_o;
    logic [7:0]            doc_q_i;
    logic [3:0]            volume_o;
    logic                  busy_o;
    logic                  overrun_o;

    modport slave (
        input  addr_i, sel_i, rw_n_i, wr_strobe_i, rd_strobe_i, data_i, mem_q_i, mem_ready_i, doc_q_i,
        output data_o, rd_en_o, mem_addr_o, mem_wr_o, mem_rd_o, mem_byte_en_o, mem_data_o,
               doc_cs_o, doc_we_o, doc_addr_o, doc_data_o, volume_o, busy_o, overrun_o
    );

    modport master (
        output addr_i, sel_i, rw_n_i, wr_strobe_i, rd_strobe_i, data_i, mem_q_i, mem_ready_i, doc_q_i,
        input  data_o, rd_en_o, mem_addr_o, mem_wr_o, mem_rd_o, mem_byte_en_o, mem_data_o,
               doc_cs_o, doc_we_o, doc_addr_o, doc_data_o, volume_o, busy_o, overrun_o
    );
endinterface

// File: rtl/sound_glu_rw.sv
// IIgs sound GLU ($C03C-$C03F): CTRL/PTR registers, DATA steered to DOC or sound RAM, one request in flight.
// Requests issue 1 cycle after the strobe; data accesses while busy are dropped and flag overrun.
// Define SOUND_GLU_READ_EN to enable the read-ahead fetch path (RD_MEM/RD_WAIT/DOC_RD/DOC_LATCH).
module sound_glu_rw #(
    parameter bit                    ENABLE     = 1'b1,
    parameter int                    MEM_ADDR_W = 21,
    parameter logic [MEM_ADDR_W-1:0] MEM_BASE   = MEM_ADDR_W'(21'h1_0000),
    parameter int                    LANES      = 4
) (
    input  logic          clk_logic,
    input  logic          system_reset,
    sound_glu_rw_if.slave bus
);
    localparam int         SH        = (LANES == 4) ? 2 : (LANES == 2) ? 1 : 0;
    localparam logic [1:0] LANE_MASK = 2'(LANES - 1);

`ifdef SOUND_GLU_READ_EN
    typedef enum logic [2:0] {IDLE, WR_MEM, RD_MEM, RD_WAIT, DOC_WR, DOC_RD, DOC_LATCH} state_t;
`else
    typedef enum logic [2:0] {IDLE, WR_MEM, DOC_WR} state_t;
`endif

    state_t                state, state_nxt;
    logic                  ram_sel, auto_inc, overrun;
    logic [3:0]            volume;
    logic [15:0]           ptr;
    logic [7:0]            latch, wdata;
    logic [MEM_ADDR_W-1:0] cap_addr;
    logic [1:0]            cap_lane;
    logic [7:0]            cap_lo;
    logic                  mem_wr, mem_rd, doc_cs, doc_we, busy;

    logic       hit, wr_hit, data_wr, data_rd, accept, drop, rd_en;
    logic [1:0] rsel;
    logic [7:0] rd_mux;

    assign hit     = bus.sel_i && (bus.addr_i[15:2] == 14'h300F);
    assign rsel    = bus.addr_i[1:0];
    assign wr_hit  = hit && bus.wr_strobe_i && !bus.rw_n_i;
    assign data_wr = wr_hit && (rsel == 2'd1);
`ifdef SOUND_GLU_READ_EN
    assign data_rd = hit && bus.rd_strobe_i && bus.rw_n_i && (rsel == 2'd1);
    assign rd_en   = hit && bus.rw_n_i;

    logic [7:0] mem_lane_q;
    always_comb begin
        mem_lane_q = bus.mem_q_i[7:0];
        for (int i = 0; i < LANES; i++) begin
            if (cap_lane == 2'(i)) mem_lane_q = bus.mem_q_i[8*i +: 8];
        end
    end
`else
    assign data_rd = 1'b0;
    assign rd_en   = 1'b0;

    logic unused_rd;
    assign unused_rd = ^{bus.rd_strobe_i, bus.mem_q_i, bus.mem_ready_i, bus.doc_q_i};
`endif
    assign accept = ENABLE && (data_wr || data_rd) && (state == IDLE);
    assign drop   = ENABLE && (data_wr || data_rd) && (state != IDLE);

    always_ff @(posedge clk_logic) begin
        if (system_reset || !ENABLE) state <= IDLE;
        else                         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (data_wr) state_nxt = ram_sel ? WR_MEM : DOC_WR;
`ifdef SOUND_GLU_READ_EN
                    else         state_nxt = ram_sel ? RD_MEM : DOC_RD;
`endif
                end
            end
            WR_MEM, DOC_WR: state_nxt = IDLE;
`ifdef SOUND_GLU_READ_EN
            RD_MEM:    state_nxt = RD_WAIT;
            RD_WAIT:   if (bus.mem_ready_i) state_nxt = IDLE;
            DOC_RD:    state_nxt = DOC_LATCH;
            DOC_LATCH: state_nxt = IDLE;
`endif
            default:   state_nxt = IDLE;
        endcase
    end

    // doc_we is high for reads: the DOC port uses a read-enable-style polarity.
    always_comb begin
        mem_wr = (state == WR_MEM);
        mem_rd = 1'b0;
        doc_cs = (state == DOC_WR);
        doc_we = 1'b0;
        busy   = (state != IDLE);
`ifdef SOUND_GLU_READ_EN
        mem_rd = (state == RD_MEM);
        doc_cs = (state == DOC_WR) || (state == DOC_RD);
        doc_we = (state == DOC_RD);
`endif
    end

    always_ff @(posedge clk_logic) begin
        if (system_reset || !ENABLE) begin
            ram_sel  <= 1'b0;
            auto_inc <= 1'b0;
            volume   <= 4'hF;
            ptr      <= 16'h0000;
            latch    <= 8'h00;
            wdata    <= 8'h00;
            overrun  <= 1'b0;
            cap_addr <= '0;
            cap_lane <= 2'd0;
            cap_lo   <= 8'h00;
        end else begin
            if (wr_hit) begin
                case (rsel)
                    2'd0: begin
                        ram_sel  <= bus.data_i[6];
                        auto_inc <= bus.data_i[5];
                        volume   <= bus.data_i[3:0];
                        overrun  <= 1'b0;
                    end
                    2'd2:    ptr[7:0]  <= bus.data_i;
                    2'd3:    ptr[15:8] <= bus.data_i;
                    default: ;
                endcase
            end
            // Address and lane are frozen here so later PTR writes cannot disturb the request.
            if (accept) begin
                cap_addr <= MEM_BASE + MEM_ADDR_W'(ptr >> SH);
                cap_lane <= ptr[1:0] & LANE_MASK;
                cap_lo   <= ptr[7:0];
                wdata    <= bus.data_i;
                if (auto_inc) ptr <= ptr + 16'd1;
            end
            if (drop) overrun <= 1'b1;
`ifdef SOUND_GLU_READ_EN
            if ((state == RD_WAIT) && bus.mem_ready_i) latch <= mem_lane_q;
            if (state == DOC_LATCH)                    latch <= bus.doc_q_i;
`endif
        end
    end

    always_comb begin
        case (rsel)
            2'd0:    rd_mux = {busy, ram_sel, auto_inc, 1'b0, volume};
            2'd1:    rd_mux = latch;
            2'd2:    rd_mux = ptr[7:0];
            default: rd_mux = ptr[15:8];
        endcase
    end

    assign bus.data_o        = ENABLE ? rd_mux : 8'h00;
    assign bus.rd_en_o       = ENABLE && rd_en;
    assign bus.mem_addr_o    = ENABLE ? cap_addr : '0;
    assign bus.mem_wr_o      = ENABLE && mem_wr;
    assign bus.mem_rd_o      = ENABLE && mem_rd;
    assign bus.mem_byte_en_o = ENABLE ? (LANES'(1) << cap_lane) : '0;
    assign bus.mem_data_o    = ENABLE ? {LANES{wdata}} : '0;
    assign bus.doc_cs_o      = ENABLE && doc_cs;
    assign bus.doc_we_o      = ENABLE && doc_we;
    assign bus.doc_addr_o    = ENABLE ? cap_lo : 8'h00;
    assign bus.doc_data_o    = ENABLE ? wdata : 8'h00;
    assign bus.volume_o      = ENABLE ? volume : 4'h0;
    assign bus.busy_o        = ENABLE && busy;
    assign bus.overrun_o     = ENABLE && overrun;
endmodule

// File: tb/tb_sound_glu_rw.sv
// Directed bench for sound_glu_rw: register table plus hand-written RAM/DOC/overrun/reset sequences.
module tb_sound_glu_rw;
    logic clk = 1'b0;
    logic system_reset;
    always #10 clk = ~clk;

    sound_glu_rw_if #(.MEM_ADDR_W(21), .LANES(4)) bus ();

    sound_glu_rw #(
        .ENABLE(1'b1), .MEM_ADDR_W(21), .MEM_BASE(21'h1_0000), .LANES(4)
    ) dut (
        .clk_logic(clk),
        .system_reset(system_reset),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;
    logic [7:0] rd_data;
    logic       rd_en_seen;
    logic [7:0] pk;

    typedef struct {
        string       name;
        logic [15:0] waddr;
        logic [7:0]  wdat;
        logic [15:0] raddr;
        logic [7:0]  exp;
    } vec_t;
    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Callers sit just after a negedge; returns at the next negedge.
    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        bus.addr_i = a; bus.sel_i = 1'b1; bus.rw_n_i = 1'b0; bus.data_i = d; bus.wr_strobe_i = 1'b1;
        @(negedge clk);
        bus.wr_strobe_i = 1'b0; bus.sel_i = 1'b0; bus.rw_n_i = 1'b1;
    endtask

    task automatic rd(input logic [15:0] a);
        bus.addr_i = a; bus.sel_i = 1'b1; bus.rw_n_i = 1'b1; bus.rd_strobe_i = 1'b1;
        #1;
        rd_data    = bus.data_o;
        rd_en_seen = bus.rd_en_o;
        @(negedge clk);
        bus.rd_strobe_i = 1'b0; bus.sel_i = 1'b0;
    endtask

    task automatic peek(input logic [15:0] a, output logic [7:0] v);
        bus.addr_i = a; bus.sel_i = 1'b1; bus.rw_n_i = 1'b1;
        #1;
        v = bus.data_o;
        bus.sel_i = 1'b0;
    endtask

    task automatic check_ptr(input string name, input logic [15:0] exp);
        logic [7:0] lo, hi;
        peek(16'hC03E, lo);
        peek(16'hC03F, hi);
        check(name, {16'h0, hi, lo}, {16'h0, exp});
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{"ctrl_ff",   16'hC03C, 8'hFF, 16'hC03C, 8'h6F};
        vecs[1] = '{"ctrl_10",   16'hC03C, 8'h10, 16'hC03C, 8'h00};
        vecs[2] = '{"ctrl_25",   16'hC03C, 8'h25, 16'hC03C, 8'h25};
        vecs[3] = '{"ptr_lo",    16'hC03E, 8'h35, 16'hC03E, 8'h35};
        vecs[4] = '{"ptr_hi",    16'hC03F, 8'h12, 16'hC03F, 8'h12};
        vecs[5] = '{"miss_c03b", 16'hC03B, 8'h99, 16'hC03E, 8'h35};
        vecs[6] = '{"miss_c13e", 16'hC13E, 8'h77, 16'hC03E, 8'h35};

        system_reset = 1'b1;
        bus.addr_i = 16'h0; bus.sel_i = 1'b0; bus.rw_n_i = 1'b1;
        bus.wr_strobe_i = 1'b0; bus.rd_strobe_i = 1'b0; bus.data_i = 8'h00;
        bus.mem_q_i = '0; bus.mem_ready_i = 1'b0; bus.doc_q_i = 8'h00;
        repeat (3) @(negedge clk);
        system_reset = 1'b0;

        // Reset state
        peek(16'hC03C, pk); check("rst_ctrl", pk, 8'h0F);
        peek(16'hC03D, pk); check("rst_latch", pk, 8'h00);
        check_ptr("rst_ptr", 16'h0000);
        check("rst_busy", bus.busy_o, 1'b0);
        check("rst_pulses", {bus.mem_wr_o, bus.mem_rd_o, bus.doc_cs_o, bus.overrun_o}, 4'b0000);
        check("rst_volume", bus.volume_o, 4'hF);

        foreach (vecs[i]) begin
            @(negedge clk);
            wr(vecs[i].waddr, vecs[i].wdat);
            peek(vecs[i].raddr, pk);
            check(vecs[i].name, pk, vecs[i].exp);
        end

        // RAM write with auto-increment
        @(negedge clk);
        wr(16'hC03C, 8'h60); wr(16'hC03E, 8'h35); wr(16'hC03F, 8'h12); wr(16'hC03D, 8'hAB);
        check("ramwr_pulse", bus.mem_wr_o, 1'b1);
        check("ramwr_addr", bus.mem_addr_o, 21'h1_048D);
        check("ramwr_be", bus.mem_byte_en_o, 4'b0010);
        check("ramwr_data", bus.mem_data_o, 32'hABABABAB);
        check("ramwr_busy", {bus.busy_o, bus.doc_cs_o, bus.mem_rd_o}, 3'b100);
        @(negedge clk);
        check("ramwr_end", {bus.mem_wr_o, bus.busy_o}, 2'b00);
        check_ptr("ramwr_ptr", 16'h1236);

        // DOC write, no auto-increment
        @(negedge clk);
        wr(16'hC03C, 8'h00); wr(16'hC03E, 8'h42); wr(16'hC03F, 8'h00); wr(16'hC03D, 8'h5C);
        check("docwr_cs_we", {bus.doc_cs_o, bus.doc_we_o, bus.mem_wr_o}, 3'b100);
        check("docwr_addr", bus.doc_addr_o, 8'h42);
        check("docwr_data", bus.doc_data_o, 8'h5C);
        check("docwr_volume", bus.volume_o, 4'h0);
        @(negedge clk);
        check("docwr_end", {bus.doc_cs_o, bus.busy_o}, 2'b00);
        check_ptr("docwr_ptr", 16'h0042);

        // Pointer wrap, then back-to-back DATA write is dropped
        @(negedge clk);
        wr(16'hC03C, 8'h60); wr(16'hC03E, 8'hFF); wr(16'hC03F, 8'hFF); wr(16'hC03D, 8'h11);
        check("wrap_addr", bus.mem_addr_o, 21'h1_3FFF);
        check("wrap_be", bus.mem_byte_en_o, 4'b1000);
        wr(16'hC03D, 8'h22);
        check("drop_overrun", bus.overrun_o, 1'b1);
        check("drop_no_req", {bus.mem_wr_o, bus.busy_o}, 2'b00);
        check("drop_wdata", bus.mem_data_o, 32'h11111111);
        check_ptr("wrap_ptr", 16'h0000);
        @(negedge clk);
        wr(16'hC03C, 8'h60);
        check("ovr_clear", bus.overrun_o, 1'b0);

`ifndef SOUND_GLU_READ_EN
        // Without the fetch path a DATA read only returns the latch.
        @(negedge clk);
        rd(16'hC03D);
        check("nord_data", rd_data, 8'h00);
        check("nord_rd_en", rd_en_seen, 1'b0);
        check("nord_no_req", {bus.mem_rd_o, bus.doc_cs_o, bus.busy_o, bus.overrun_o}, 4'b0000);
        check_ptr("nord_ptr", 16'h0000);
`else
        // RAM read-ahead with an overrun while RD_WAIT
        @(negedge clk);
        wr(16'hC03C, 8'h60); wr(16'hC03E, 8'h02); wr(16'hC03F, 8'h00);
        rd(16'hC03D);
        check("rd1_data", rd_data, 8'h00);
        check("rd1_rd_en", rd_en_seen, 1'b1);
        check("rd1_pulse", bus.mem_rd_o, 1'b1);
        check("rd1_addr", bus.mem_addr_o, 21'h1_0000);
        check("rd1_be", bus.mem_byte_en_o, 4'b0100);
        @(negedge clk);
        peek(16'hC03C, pk); check("rd1_ctrl_busy", pk, 8'hE0);
        rd(16'hC03D);
        check("rdwait_overrun", bus.overrun_o, 1'b1);
        check("rdwait_no_req", {bus.mem_rd_o, bus.busy_o}, 2'b01);
        repeat (3) @(negedge clk);
        bus.mem_q_i = 32'h44332211; bus.mem_ready_i = 1'b1;
        @(negedge clk);
        bus.mem_ready_i = 1'b0;
        check("rd1_done", bus.busy_o, 1'b0);
        check_ptr("rd1_ptr", 16'h0003);
        wr(16'hC03C, 8'h60);
        rd(16'hC03D);
        check("rd2_data", rd_data, 8'h33);
        check("rd2_be", bus.mem_byte_en_o, 4'b1000);
        @(negedge clk);
        bus.mem_q_i = 32'h88776655; bus.mem_ready_i = 1'b1;
        @(negedge clk);
        bus.mem_ready_i = 1'b0;
        peek(16'hC03D, pk); check("rd2_latch", pk, 8'h88);
        check_ptr("rd2_ptr", 16'h0004);
        bus.mem_q_i = 32'hDEADBEEF; bus.mem_ready_i = 1'b1;
        @(negedge clk);
        bus.mem_ready_i = 1'b0;
        peek(16'hC03D, pk); check("stray_ready", pk, 8'h88);

        // DOC read-ahead
        @(negedge clk);
        wr(16'hC03C, 8'h20); wr(16'hC03E, 8'hE0); wr(16'hC03F, 8'h00);
        rd(16'hC03D);
        check("docrd1_data", rd_data, 8'h88);
        check("docrd_cs_we", {bus.doc_cs_o, bus.doc_we_o}, 2'b11);
        check("docrd_addr", bus.doc_addr_o, 8'hE0);
        bus.doc_q_i = 8'h5A;
        @(negedge clk);
        check("docrd_latch_state", {bus.doc_cs_o, bus.busy_o}, 2'b01);
        @(negedge clk);
        bus.doc_q_i = 8'h00;
        check("docrd_idle", bus.busy_o, 1'b0);
        check_ptr("docrd_ptr", 16'h00E1);
        rd(16'hC03D);
        check("docrd2_data", rd_data, 8'h5A);
        repeat (2) @(negedge clk);
        check_ptr("docrd2_ptr", 16'h00E2);

        // Reset during RD_WAIT; a late mem_ready_i must be ignored
        @(negedge clk);
        wr(16'hC03C, 8'h60);
        rd(16'hC03D);
        @(negedge clk);
        system_reset = 1'b1;
        @(negedge clk);
        system_reset = 1'b0;
        check("rstmid_busy", bus.busy_o, 1'b0);
        bus.mem_q_i = 32'h99999999; bus.mem_ready_i = 1'b1;
        @(negedge clk);
        bus.mem_ready_i = 1'b0;
        check("rstmid_quiet", {bus.busy_o, bus.mem_rd_o, bus.mem_wr_o}, 3'b000);
        peek(16'hC03D, pk); check("rstmid_latch", pk, 8'h00);
        peek(16'hC03C, pk); check("rstmid_ctrl", pk, 8'h0F);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sound_glu_rw.md
# sound_glu_rw

Parametrised, read-capable successor of the IIgs sound GLU. It decodes $C03C-$C03F and holds the control and pointer registers. Data-register accesses are steered either to the DOC register port or to dedicated sound RAM through a single-outstanding SDRAM request FSM. Reads follow IIgs semantics: data is read ahead, with a busy flag and pointer auto-increment.

## Interface
**Parameters**
- ENABLE, 1 — 0 ties off all outputs and requests; registers stay at reset values.
- MEM_ADDR_W, 21 — width of the word address to SDRAM.
- MEM_BASE, 21'h1_0000 — word address of sound RAM byte 0.
- LANES, 4 — bytes per SDRAM word; must be 1, 2 or 4.

**Ports**
- clk_logic — in, 1 — sole clock.
- system_reset — in, 1 — synchronous, active-high.
- addr_i — in, 16 — bus address.
- sel_i — in, 1 — phi0 & !m2sel_n qualifier.
- rw_n_i — in, 1 — 1 = read.
- wr_strobe_i — in, 1 — one-cycle pulse; bus write data valid.
- rd_strobe_i — in, 1 — one-cycle pulse per bus read cycle.
- data_i — in, 8 — bus write data.
- data_o — out, 8 — read mux output.
- rd_en_o — out, 1 — drive bus (sel_i & address hit & rw_n_i).
- mem_addr_o — out, MEM_ADDR_W — MEM_BASE + ptr/LANES.
- mem_wr_o, mem_rd_o — out, 1 — one-cycle request pulses.
- mem_byte_en_o — out, LANES — one-hot lane ptr%LANES.
- mem_data_o — out, 8*LANES — data_i replicated.
- mem_q_i — in, 8*LANES; mem_ready_i — in, 1 — read return.
- doc_cs_o — out, 1; doc_we_o — out, 1; doc_addr_o — out, 8 (=ptr_lo); doc_data_o — out, 8.
- doc_q_i — in, 8 — DOC read data, valid the cycle after doc_cs_o.
- volume_o — out, 4; busy_o — out, 1; overrun_o — out, 1.

## Operation
- Registers:
  - CTRL $C03C: bit7 busy (read-only), bit6 RAM(1)/DOC(0), bit5 auto-inc, bit4 reads 0, bits3:0 volume.
  - DATA $C03D reads the data latch.
  - PTR_LO $C03E, PTR_HI $C03F.
- Reset values: CTRL 0x0F, latch 0x00, ptr 0x0000, all strobes 0, busy_o 0, overrun_o 0, FSM IDLE.
- FSM states: IDLE, WR_MEM, RD_MEM, RD_WAIT, DOC_WR, DOC_RD, DOC_LATCH.
- Data write, accepted in IDLE:
  - RAM → WR_MEM: mem_wr_o pulses, then IDLE.
  - DOC → DOC_WR: doc_cs_o=1, doc_we_o=0 for one cycle, then IDLE.
- Data read, accepted in IDLE:
  - data_o returns the current latch (previous fetch); the first read after a pointer change is stale by design.
  - RAM → RD_MEM: mem_rd_o pulses → RD_WAIT; on mem_ready_i the latch takes mem_q_i lane (captured ptr%LANES) → IDLE.
  - DOC → DOC_RD: doc_cs_o=1, doc_we_o=1 → DOC_LATCH: latch takes doc_q_i → IDLE.
- Auto-increment: if CTRL[5], ptr increments by 1 in the request-issue cycle; mem address and lane are captured before the increment.
- Pointer wrap: 0xFFFF → 0x0000.
- busy_o = CTRL[7] = (state != IDLE).
- Data access while busy: dropped (no request, no increment); overrun_o set sticky. overrun_o clears on any CTRL write.
- CTRL/PTR writes are accepted in any state and take effect the cycle after wr_strobe_i. An in-flight request keeps its captured address and lane.
- mem_ready_i outside RD_WAIT is ignored.

## Timing
- Request pulse appears 1 cycle after the strobe.
- RAM read latency: latch is updated in the cycle mem_ready_i is high; busy_o drops the next cycle.
- DOC read: latch valid 3 cycles after rd_strobe_i.
- DOC write: doc_cs_o 1 cycle after wr_strobe_i, held 1 cycle.
- Reset mid-operation: next cycle FSM is IDLE, no pulses, and a late mem_ready_i is ignored.
- data_o is combinational from addr_i[1:0] and registers.

## Configuration
- SOUND_GLU_READ_EN:
  - Defined: read-ahead fetch path as above.
  - Undefined:
    - DATA reads return the latch only, with no fetch, no increment, and no mem_rd_o/doc read.
    - RD_MEM, RD_WAIT, DOC_RD and DOC_LATCH are removed.
    - rd_en_o is forced to 0.

## Test plan
- Reset → CTRL read 0x0F, ptr 0x0000, busy_o 0, all pulses 0.
- CTRL=0x60, PTR=0x1235, write 0xAB to DATA → one mem_wr_o, mem_addr_o=0x1_048D, byte_en=0b0010, mem_data_o=0xABABABAB, ptr becomes 0x1236.
- CTRL=0x60, PTR=0x0002, two DATA reads with mem_q_i=0x44332211 returned 5 cycles after mem_rd_o → first read 0x00, second read 0x33, ptr 0x0004.
- CTRL=0x20, PTR=0x00E0, DATA read with doc_q_i=0x5A → doc_addr_o=0xE0, doc_we_o=1; next read returns 0x5A; ptr 0x00E1.
- PTR=0xFFFF, auto-inc RAM write → ptr 0x0000. DATA strobe issued while RD_WAIT → no request, overrun_o=1; CTRL write clears it.
- system_reset during RD_WAIT, then mem_ready_i → latch stays 0x00, busy_o 0.
